img_row_sched: RTL and testbench

- Sequences one filter pass over an image held in a 512x640 row buffer (one row = 80 pixels x 8 bits).
- Reads source rows, builds a sliding 3-row window (top/mid/bot) with edge-clamp padding, and hands it to the coprocessor filter engine over a valid/ready handshake.
- Writes the engine's in-order result rows into the destination row buffer, then signals done.
- Sits between the coproc command decoder (start/num_rows) and the source/destination row buffer instances.

---
 rtl/img_row_sched.sv | 125 ++++++++++++
 tb/tb_img_row_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_row_sched.sv
// Filter-pass sequencer: streams clamped 3-row windows to the filter engine
// and writes its in-order result rows to the destination row buffer.
module img_row_sched #(
  parameter int ADDR_W = 9,
  parameter int ROW_W  = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_raddr,
  input  logic [ROW_W-1:0]  src_rdata,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [ADDR_W-1:0] win_row,
  output logic [ROW_W-1:0]  win_top,
  output logic [ROW_W-1:0]  win_mid,
  output logic [ROW_W-1:0]  win_bot,
  input  logic              res_valid,
  input  logic [ROW_W-1:0]  res_data,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_waddr,
  output logic [ROW_W-1:0]  dst_wdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD0    = 3'd1;
  localparam logic [2:0] CAP0   = 3'd2;
  localparam logic [2:0] CAP1   = 3'd3;
  localparam logic [2:0] WIN    = 3'd4;
  localparam logic [2:0] SHIFT  = 3'd5;
  localparam logic [2:0] WAITWR = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0]        state;
  logic [ADDR_W-1:0] nrows;
  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] wcnt;
  logic              last_wr;

  // Read addresses saturate at the last row instead of wrapping.
  function automatic logic [ADDR_W-1:0] clamp(
    input logic [ADDR_W:0]   a,
    input logic [ADDR_W-1:0] lim
  );
    return (a > {1'b0, lim}) ? lim : a[ADDR_W-1:0];
  endfunction

  assign last      = nrows - 1'b1;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign win_valid = (state == WIN);
  assign dst_we    = res_valid && busy;
  assign dst_waddr = wcnt;
  assign dst_wdata = res_data;
  assign last_wr   = dst_we && (wcnt == last);

  always_comb begin
    src_raddr = '0;
    case (state)
      CAP0:       src_raddr = clamp((ADDR_W+1)'(1), last);
      CAP1:       src_raddr = clamp((ADDR_W+1)'(2), last);
      WIN, SHIFT: src_raddr = clamp({1'b0, win_row} + (ADDR_W+1)'(2), last);
      default:    src_raddr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      nrows   <= '0;
      wcnt    <= '0;
      win_row <= '0;
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else begin
      if (dst_we) wcnt <= wcnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            nrows   <= num_rows;
            wcnt    <= '0;
            win_row <= '0;
            state   <= (num_rows == '0) ? DONE : RD0;
          end
        end
        RD0: state <= CAP0;
        CAP0: begin
          win_top <= src_rdata;
          win_mid <= src_rdata;
          state   <= CAP1;
        end
        CAP1: begin
          win_bot <= src_rdata;
          state   <= WIN;
        end
        WIN: begin
          if (win_ready) begin
            if (win_row == last) begin
              state <= WAITWR;
            end else begin
              win_top <= win_mid;
              win_mid <= win_bot;
              win_row <= win_row + 1'b1;
              state   <= SHIFT;
            end
          end
        end
        // Data for row win_row+1 was addressed during WIN.
        SHIFT: begin
          win_bot <= src_rdata;
          state   <= WIN;
        end
        WAITWR: state <= WAITWR;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
      if (last_wr) state <= DONE;
    end
  end

endmodule

// File: tb/tb_img_row_sched.sv
// Scoreboard bench for img_row_sched with a row-buffer model and an
// echo engine that returns win_mid three cycles after each accepted window.
module tb_img_row_sched;

  localparam int AW = 9;
  localparam int RW = 640;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [AW-1:0] num_rows, src_raddr, win_row, dst_waddr;
  logic [RW-1:0] src_rdata, win_top, win_mid, win_bot;
  logic [RW-1:0] res_data, dst_wdata;
  logic          win_valid, win_ready, res_valid, dst_we;

  typedef struct {
    logic [AW-1:0] row;
    logic [RW-1:0] top, mid, bot;
  } win_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;
  typedef struct {
    int            due;
    logic [RW-1:0] data;
  } res_t;

  win_t wq[$];
  wr_t  xq[$];
  res_t eq[$];

  logic [RW-1:0] mem [512];

  int checks = 0, errors = 0;
  int exp_done = 0, done_cnt = 0, cyc = 0;
  bit mon_en = 1'b1, stray = 1'b0;

  img_row_sched #(.ADDR_W(AW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .src_raddr(src_raddr),
    .src_rdata(src_rdata), .win_valid(win_valid),
    .win_ready(win_ready), .win_row(win_row), .win_top(win_top),
    .win_mid(win_mid), .win_bot(win_bot), .res_valid(res_valid),
    .res_data(res_data), .dst_we(dst_we), .dst_waddr(dst_waddr),
    .dst_wdata(dst_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) src_rdata <= mem[src_raddr];

  function automatic logic [RW-1:0] rowval(input int b);
    logic [7:0] v;
    v = b[7:0];
    return {80{v}};
  endfunction

  // Engine: drive results at +1 after negedge, detect handshakes at +2.
  res_t e;
  always @(negedge clk) begin
    #1;
    res_valid = stray;
    res_data  = '0;
    if (eq.size() > 0 && eq[0].due == cyc + 1) begin
      res_valid = 1'b1;
      res_data  = eq[0].data;
      void'(eq.pop_front());
    end
    #1;
    if (win_valid && win_ready) begin
      e.due  = cyc + 4;
      e.data = win_mid;
      eq.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    #2;
    if (done) done_cnt++;
    if (mon_en) begin
      if (win_valid) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL win_extra: row %0d presented, expected none", win_row);
        end else begin
          if (win_row !== wq[0].row || win_top !== wq[0].top ||
              win_mid !== wq[0].mid || win_bot !== wq[0].bot) begin
            errors++;
            $display("FAIL win: got row %0d bytes %h/%h/%h, expected row %0d bytes %h/%h/%h",
                     win_row, win_top[7:0], win_mid[7:0], win_bot[7:0],
                     wq[0].row, wq[0].top[7:0], wq[0].mid[7:0], wq[0].bot[7:0]);
          end
          if (win_ready) void'(wq.pop_front());
        end
      end
      if (dst_we) begin
        checks++;
        if (xq.size() == 0) begin
          errors++;
          $display("FAIL wr_extra: addr %0d written, expected no write", dst_waddr);
        end else begin
          if (dst_waddr !== xq[0].addr || dst_wdata !== xq[0].data) begin
            errors++;
            $display("FAIL wr: got addr %0d byte %h, expected addr %0d byte %h",
                     dst_waddr, dst_wdata[7:0], xq[0].addr, xq[0].data[7:0]);
          end
          void'(xq.pop_front());
        end
      end
      if (done) begin
        checks++;
        if (exp_done == 0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done: got done with busy=%b pending=%0d, expected busy 0 pending>0",
                   busy, exp_done);
        end
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic chk(input string nm, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act[31:0], exp[31:0]);
    end
  endtask

  task automatic push_pass(input int n);
    win_t w;
    wr_t  x;
    for (int r = 0; r < n; r++) begin
      w.row = r[AW-1:0];
      w.top = rowval((r > 0 ? r - 1 : 0) + 1);
      w.mid = rowval(r + 1);
      w.bot = rowval((r < n - 1 ? r + 1 : n - 1) + 1);
      wq.push_back(w);
      x.addr = r[AW-1:0];
      x.data = rowval(r + 1);
      xq.push_back(x);
    end
    exp_done++;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start    = 1'b1;
    num_rows = n[AW-1:0];
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_win(input int r, input int budget, input string nm);
    int k;
    bit hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge clk);
      #1;
      hit = win_valid && (win_row == r[AW-1:0]);
      k++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: window row %0d not seen within %0d cycles", nm, r, budget);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, RW'(busy), '0);
    chk({nm, "_done"}, RW'(done), '0);
    chk({nm, "_wvalid"}, RW'(win_valid), '0);
    chk({nm, "_dwe"}, RW'(dst_we), '0);
    chk({nm, "_raddr"}, RW'(src_raddr), '0);
    chk({nm, "_wrow"}, RW'(win_row), '0);
    chk({nm, "_waddr"}, RW'(dst_waddr), '0);
    chk({nm, "_top"}, win_top, '0);
    chk({nm, "_mid"}, win_mid, '0);
    chk({nm, "_bot"}, win_bot, '0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = rowval(i + 1);
    rst       = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic pass N=4 with startup timing
    push_pass(4);
    pulse_start(4);
    #2;
    chk("t1_raddr", RW'(src_raddr), RW'(0));
    chk("t1_wv", RW'(win_valid), '0);
    @(negedge clk);
    #2 chk("t2_raddr", RW'(src_raddr), RW'(1));
    @(negedge clk);
    #2;
    chk("t3_raddr", RW'(src_raddr), RW'(2));
    chk("t3_wv", RW'(win_valid), '0);
    @(negedge clk);
    #2 chk("t4_wv", RW'(win_valid), RW'(1));
    wait_done(100, "pass4");
    @(negedge clk);
    #2 chk("pass4_busy_after", RW'(busy), '0);

    // Stall on r=1 for 5 cycles
    push_pass(4);
    pulse_start(4);
    wait_win(1, 50, "stall_wait");
    win_ready = 1'b0;
    repeat (5) @(negedge clk);
    win_ready = 1'b1;
    wait_done(100, "stall_pass");

    // N=1 and N=0
    push_pass(1);
    pulse_start(1);
    wait_done(50, "n1");
    push_pass(0);
    pulse_start(0);
    #2 chk("n0_done", RW'(done), RW'(1));
    @(negedge clk);
    #2;
    chk("n0_done_clr", RW'(done), '0);
    chk("n0_busy", RW'(busy), '0);

    // Restart ignored mid-pass, then stray result after done
    push_pass(4);
    pulse_start(4);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    num_rows = 9'd7;
    @(negedge clk);
    start    = 1'b0;
    wait_done(100, "restart_pass");
    @(negedge clk);
    stray = 1'b1;
    #2 chk("stray_dwe", RW'(dst_we), '0);
    @(negedge clk);
    stray = 1'b0;

    // Reset in WIN at r=2, then fresh N=3 pass
    mon_en = 1'b0;
    pulse_start(4);
    wait_win(2, 50, "rst_wait");
    win_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    #2 chk_zero("midrst");
    #1;
    rst       = 1'b0;
    win_ready = 1'b1;
    eq.delete();
    mon_en    = 1'b1;
    push_pass(3);
    pulse_start(3);
    wait_done(100, "pass3");
    repeat (4) @(negedge clk);

    #2;
    chk("end_win_q", RW'(wq.size()), '0);
    chk("end_wr_q", RW'(xq.size()), '0);
    chk("end_done_q", RW'(exp_done), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
